// File: rtl/rx_req_responder_if.sv
// Read-request handshake and engine completion lanes shared by the responder
// (slave) and the requester/engine model (master).
interface rx_req_responder_if #(
    parameter int C_DATA_WIDTH      = 128,
    parameter int C_DATA_WORD_WIDTH = $clog2((C_DATA_WIDTH / 32) + 1)
);
    logic                         RX_REQ;
    logic                         RX_REQ_ACK;
    logic [1:0]                   RX_REQ_TAG;
    logic [63:0]                  RX_REQ_ADDR;
    logic [9:0]                   RX_REQ_LEN;
    logic                         ENG_STALL;
    logic [C_DATA_WIDTH-1:0]      ENG_DATA;
    logic [C_DATA_WORD_WIDTH-1:0] MAIN_DATA_EN;
    logic [C_DATA_WORD_WIDTH-1:0] SG_RX_DATA_EN;
    logic [C_DATA_WORD_WIDTH-1:0] SG_TX_DATA_EN;
    logic                         MAIN_DONE;
    logic                         SG_RX_DONE;
    logic                         SG_TX_DONE;
    logic                         MAIN_ERR;
    logic                         SG_RX_ERR;
    logic                         SG_TX_ERR;
    logic [2:0]                   REQ_PENDING;

    modport master (
        output RX_REQ, RX_REQ_TAG, RX_REQ_ADDR, RX_REQ_LEN, ENG_STALL,
        input  RX_REQ_ACK, ENG_DATA, MAIN_DATA_EN, SG_RX_DATA_EN, SG_TX_DATA_EN,
        input  MAIN_DONE, SG_RX_DONE, SG_TX_DONE, MAIN_ERR, SG_RX_ERR, SG_TX_ERR,
        input  REQ_PENDING
    );

    modport slave (
        input  RX_REQ, RX_REQ_TAG, RX_REQ_ADDR, RX_REQ_LEN, ENG_STALL,
        output RX_REQ_ACK, ENG_DATA, MAIN_DATA_EN, SG_RX_DATA_EN, SG_TX_DATA_EN,
        output MAIN_DONE, SG_RX_DONE, SG_TX_DONE, MAIN_ERR, SG_RX_ERR, SG_TX_ERR,
        output REQ_PENDING
    );
endinterface

// File: rtl/rx_req_responder.sv
// Queues up to four read requests and streams address-pattern completions onto
// the MAIN / SG_RX / SG_TX engine lanes selected by each request's tag.
module rx_req_responder #(
    parameter int C_DATA_WIDTH      = 128,
    parameter int C_DATA_WORD_WIDTH = $clog2((C_DATA_WIDTH / 32) + 1),
    parameter int C_QUEUE_DEPTH     = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    rx_req_responder_if.slave bus
);
    localparam int WPB = C_DATA_WIDTH / 32;
    localparam int EW  = C_DATA_WORD_WIDTH;
    localparam int PW  = $clog2(C_QUEUE_DEPTH);
    localparam int FW  = PW + 1;
    localparam logic [10:0] WPB_W   = 11'(WPB);
    localparam logic [2:0]  DEPTH_W = 3'(C_QUEUE_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_ERROR} state_t;
    typedef struct packed {
        logic [1:0]  tag;
        logic [29:0] addr;
        logic [9:0]  len;
    } req_t;

    state_t                  state_q, state_d;
    req_t                    mem_q [C_QUEUE_DEPTH];
    req_t                    head;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]           fill_q, fill_d;
    logic [2:0]              pending_q, pending_d;
    logic                    ack_q;
    logic [29:0]             addr_q, addr_d, cur_addr;
    logic [10:0]             rem_q, rem_d, cur_rem, beat_n;
    logic [1:0]              tag_q, tag_d, cur_tag;
    logic                    capture, pop, beat, finish, err_beat;
    logic [C_DATA_WIDTH-1:0] beat_data, data_q, data_d;
    logic [EW-1:0]           en_q [3];
    logic [EW-1:0]           en_d [3];
    logic [2:0]              done_q, done_d;
    logic                    err_q, err_d;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{bus.RX_REQ_ADDR[63:32], bus.RX_REQ_ADDR[1:0]};
    assign head = mem_q[rd_ptr_q];

    // A full queue may still accept on the edge whose DONE frees an entry.
    assign capture   = bus.RX_REQ && !ack_q && ((pending_q < DEPTH_W) || finish);
    assign fill_d    = fill_q + FW'(capture) - FW'(pop);
    assign pending_d = pending_q + 3'(capture) - 3'(finish);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // The pop edge already drives the first beat so queued responses run back to back.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        beat     = 1'b0;
        finish   = 1'b0;
        err_beat = 1'b0;
        cur_addr = addr_q;
        cur_rem  = rem_q;
        cur_tag  = tag_q;
        if (!bus.ENG_STALL) begin
            case (state_q)
                S_IDLE: begin
                    if (fill_q != '0) begin
                        pop      = 1'b1;
                        cur_addr = head.addr;
                        cur_rem  = (head.len == 10'd0) ? 11'd1024 : {1'b0, head.len};
                        cur_tag  = head.tag;
                        if (head.tag == 2'd3) begin
                            state_d = S_ERROR;
                        end else begin
                            beat    = 1'b1;
                            state_d = S_STREAM;
                        end
                    end
                end
                S_STREAM: beat = 1'b1;
                S_ERROR: begin
                    err_beat = 1'b1;
                    finish   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        beat_n = (cur_rem < WPB_W) ? cur_rem : WPB_W;
        if (beat && (cur_rem <= WPB_W)) begin
            finish  = 1'b1;
            state_d = S_IDLE;
        end
        addr_d = addr_q;
        rem_d  = rem_q;
        tag_d  = tag_q;
        if (beat || pop) begin
            addr_d = beat ? (cur_addr + 30'(beat_n)) : cur_addr;
            rem_d  = beat ? (cur_rem - beat_n) : cur_rem;
            tag_d  = cur_tag;
        end
    end

    for (genvar gi = 0; gi < WPB; gi++) begin : g_word
        assign beat_data[32*gi +: 32] = (11'(gi) < beat_n) ? {cur_addr + 30'(gi), 2'b00} : 32'd0;
    end

    always_comb begin
        data_d = data_q;
        en_d[0] = '0;
        en_d[1] = '0;
        en_d[2] = '0;
        done_d  = 3'b000;
        err_d   = 1'b0;
        if (beat) begin
            data_d = beat_data;
            case (cur_tag)
                2'd0: begin en_d[0] = EW'(beat_n); done_d[0] = finish; end
                2'd1: begin en_d[1] = EW'(beat_n); done_d[1] = finish; end
                2'd2: begin en_d[2] = EW'(beat_n); done_d[2] = finish; end
                default: ;
            endcase
        end
        if (err_beat) begin
            done_d[0] = 1'b1;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (capture) mem_q[wr_ptr_q] <= {bus.RX_REQ_TAG, bus.RX_REQ_ADDR[31:2], bus.RX_REQ_LEN};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            pending_q <= '0;
            ack_q     <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            en_q[0]   <= '0;
            en_q[1]   <= '0;
            en_q[2]   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (capture) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            fill_q    <= fill_d;
            pending_q <= pending_d;
            ack_q     <= capture;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            en_q[0]   <= en_d[0];
            en_q[1]   <= en_d[1];
            en_q[2]   <= en_d[2];
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.RX_REQ_ACK    = ack_q;
    assign bus.ENG_DATA      = data_q;
    assign bus.MAIN_DATA_EN  = en_q[0];
    assign bus.SG_RX_DATA_EN = en_q[1];
    assign bus.SG_TX_DATA_EN = en_q[2];
    assign bus.MAIN_DONE     = done_q[0];
    assign bus.SG_RX_DONE    = done_q[1];
    assign bus.SG_TX_DONE    = done_q[2];
    assign bus.MAIN_ERR      = err_q;
    assign bus.SG_RX_ERR     = 1'b0;
    assign bus.SG_TX_ERR     = 1'b0;
    assign bus.REQ_PENDING   = pending_q;
endmodule

// File: tb/tb_rx_req_responder.sv
// Scoreboard bench for rx_req_responder: accepted requests are queued as expected
// responses and a monitor checks every engine beat against a word-level model.
module tb_rx_req_responder;
    localparam int DW  = 128;
    localparam int WPB = DW / 32;
    localparam int EW  = $clog2(WPB + 1);
    localparam longint WRAP = 64'd1 << 30;

    typedef struct {
        int     tag;
        longint addr;
        int     len;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_req_responder_if #(.C_DATA_WIDTH(DW)) bus_if ();
    rx_req_responder #(.C_DATA_WIDTH(DW)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus_if));

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     mon_active = 1'b0;
    exp_t   cur;
    longint next_addr = 0;
    int     rem = 0;
    int     resp_beats = 0, resp_cycles = 0, last_beats = 0, last_cycles = 0;
    int     done_cnt = 0, err_cnt = 0, pend_model = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk(input int tag, input logic [63:0] addr, input int len);
        exp_t e;
        e.tag  = tag;
        e.addr = longint'(addr[31:2]);
        e.len  = len;
        return e;
    endfunction

    // Monitor: pops an expected response on its first active beat and walks its words.
    always @(negedge clk) begin : monitor
        int busy;
        int n;
        int exp_en [3];
        bit exp_dn [3];
        bit exp_er [3];
        logic [127:0] exp_data;
        if (!rst_n) begin
            exp_q.delete();
            mon_active = 1'b0;
            pend_model = 0;
        end else begin
            if (bus_if.RX_REQ_ACK) pend_model++;
            if (bus_if.MAIN_DONE || bus_if.SG_RX_DONE || bus_if.SG_TX_DONE) pend_model--;
            chk("req_pending", 128'(bus_if.REQ_PENDING), 128'(pend_model));
            busy = 0;
            if (bus_if.MAIN_DATA_EN != 0 || bus_if.MAIN_DONE || bus_if.MAIN_ERR) busy++;
            if (bus_if.SG_RX_DATA_EN != 0 || bus_if.SG_RX_DONE || bus_if.SG_RX_ERR) busy++;
            if (bus_if.SG_TX_DATA_EN != 0 || bus_if.SG_TX_DONE || bus_if.SG_TX_ERR) busy++;
            if (busy > 0) begin
                chk("lane_exclusive", 128'(busy), 128'd1);
                if (!mon_active) begin
                    chk("beat_has_request", 128'(exp_q.size() > 0), 128'd1);
                    if (exp_q.size() > 0) begin
                        cur         = exp_q.pop_front();
                        mon_active  = 1'b1;
                        next_addr   = cur.addr;
                        rem         = (cur.len == 0) ? 1024 : cur.len;
                        resp_beats  = 0;
                        resp_cycles = 0;
                    end
                end
            end
            if (mon_active) begin
                resp_cycles++;
                if (busy > 0) begin
                    resp_beats++;
                    for (int l = 0; l < 3; l++) begin
                        exp_en[l] = 0;
                        exp_dn[l] = 1'b0;
                        exp_er[l] = 1'b0;
                    end
                    if (cur.tag == 3) begin
                        exp_dn[0] = 1'b1;
                        exp_er[0] = 1'b1;
                        rem = 0;
                    end else begin
                        n = (rem < WPB) ? rem : WPB;
                        exp_en[cur.tag] = n;
                        rem -= n;
                        exp_dn[cur.tag] = (rem == 0);
                        exp_data = '0;
                        for (int i = 0; i < n; i++)
                            exp_data[32*i +: 32] = 32'(((next_addr + i) % WRAP) * 4);
                        next_addr = (next_addr + n) % WRAP;
                        chk("eng_data", bus_if.ENG_DATA, exp_data);
                    end
                    chk("lane_outputs",
                        128'({bus_if.MAIN_DATA_EN, bus_if.SG_RX_DATA_EN, bus_if.SG_TX_DATA_EN,
                              bus_if.MAIN_DONE, bus_if.SG_RX_DONE, bus_if.SG_TX_DONE,
                              bus_if.MAIN_ERR, bus_if.SG_RX_ERR, bus_if.SG_TX_ERR}),
                        128'({EW'(exp_en[0]), EW'(exp_en[1]), EW'(exp_en[2]),
                              exp_dn[0], exp_dn[1], exp_dn[2], exp_er[0], exp_er[1], exp_er[2]}));
                    if (rem == 0) begin
                        mon_active  = 1'b0;
                        last_beats  = resp_beats;
                        last_cycles = resp_cycles;
                        done_cnt++;
                        if (cur.tag == 3) err_cnt++;
                    end
                end
            end
        end
    end

    task automatic send_req(input int tag, input logic [63:0] addr, input int len, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        bus_if.RX_REQ_TAG  = 2'(tag);
        bus_if.RX_REQ_ADDR = addr;
        bus_if.RX_REQ_LEN  = 10'(len);
        bus_if.RX_REQ      = 1'b1;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (bus_if.RX_REQ_ACK) got = 1'b1;
        end
        if (got) exp_q.push_back(mk(tag, addr, len));
        bus_if.RX_REQ = 1'b0;
        chk("req_acked", 128'(got), 128'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < budget && !idle; c++) begin
            @(negedge clk);
            #1;
            if (!mon_active && exp_q.size() == 0 && bus_if.REQ_PENDING == 3'd0) idle = 1'b1;
        end
        chk("idle_reached", 128'(idle), 128'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat, d0, e0, issued, rtag, rlen;
        bit held, got, req_out;
        logic [63:0] raddr;

        bus_if.RX_REQ = 1'b0;
        bus_if.RX_REQ_TAG = '0;
        bus_if.RX_REQ_ADDR = '0;
        bus_if.RX_REQ_LEN = '0;
        bus_if.ENG_STALL = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_eng_data", bus_if.ENG_DATA, 128'd0);
        chk("reset_ctrl", 128'({bus_if.RX_REQ_ACK, bus_if.MAIN_DATA_EN, bus_if.SG_RX_DATA_EN,
                                bus_if.SG_TX_DATA_EN, bus_if.MAIN_DONE, bus_if.SG_RX_DONE,
                                bus_if.SG_TX_DONE, bus_if.MAIN_ERR, bus_if.SG_RX_ERR,
                                bus_if.SG_TX_ERR, bus_if.REQ_PENDING}), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic MAIN request with exact latency and data
        send_req(0, 64'h1000, 6, lat);
        chk("ack_latency", 128'(lat), 128'd1);
        @(negedge clk); #1;
        chk("basic_b1_en", 128'(bus_if.MAIN_DATA_EN), 128'd4);
        chk("basic_b1_data", bus_if.ENG_DATA, 128'h0000100C_00001008_00001004_00001000);
        @(negedge clk); #1;
        chk("basic_b2_en", 128'(bus_if.MAIN_DATA_EN), 128'd2);
        chk("basic_b2_data", bus_if.ENG_DATA, 128'h00000000_00000000_00001014_00001010);
        chk("basic_b2_done", 128'(bus_if.MAIN_DONE), 128'd1);
        wait_idle(50);

        // Max length on SG_RX, crossing the 30-bit word-address wrap
        send_req(1, 64'h0000_0000_FFFF_FE00, 0, lat);
        wait_idle(400);
        chk("maxlen_beats", 128'(last_beats), 128'd256);
        chk("maxlen_cycles", 128'(last_cycles), 128'd256);

        // Unsupported tag
        e0 = err_cnt;
        send_req(3, 64'h5000, 8, lat);
        wait_idle(50);
        chk("err_resp_count", 128'(err_cnt - e0), 128'd1);
        chk("err_pending", 128'(bus_if.REQ_PENDING), 128'd0);

        // Three stalled cycles inside a five-beat response
        send_req(2, 64'h0000_1234_0000_2000, 20, lat);
        @(negedge clk); #1;
        chk("stall_first_beat", 128'(resp_beats), 128'd1);
        bus_if.ENG_STALL = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_if.ENG_STALL = 1'b0;
        wait_idle(50);
        chk("stall_cycles", 128'(last_cycles), 128'd8);
        chk("stall_beats", 128'(last_beats), 128'd5);

        // Queue full: four accepted under stall, fifth waits for a DONE
        d0 = done_cnt;
        bus_if.ENG_STALL = 1'b1;
        send_req(0, 64'h0001_0000, 64, lat);
        send_req(1, 64'h0002_0000, 64, lat);
        send_req(2, 64'h0003_0000, 64, lat);
        send_req(0, 64'h0004_0000, 64, lat);
        chk("full_pending", 128'(bus_if.REQ_PENDING), 128'd4);
        bus_if.RX_REQ_TAG = 2'd1;
        bus_if.RX_REQ_ADDR = 64'h0005_0000;
        bus_if.RX_REQ_LEN = 10'd64;
        bus_if.RX_REQ = 1'b1;
        held = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.RX_REQ_ACK) held = 1'b0;
        end
        chk("full_hold", 128'(held), 128'd1);
        bus_if.ENG_STALL = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (bus_if.RX_REQ_ACK) got = 1'b1;
        end
        if (got) exp_q.push_back(mk(1, 64'h0005_0000, 64));
        #1 bus_if.RX_REQ = 1'b0;
        chk("fifth_acked", 128'(got), 128'd1);
        chk("fifth_after_done", 128'(done_cnt - d0 >= 1), 128'd1);
        wait_idle(1000);
        chk("full_all_done", 128'(done_cnt - d0), 128'd5);

        // Reset during the second beat of a 64-word response
        send_req(0, 64'h8000, 64, lat);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rst_second_beat", 128'(resp_beats), 128'd2);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_clears_data", bus_if.ENG_DATA, 128'd0);
        chk("rst_clears_ctrl", 128'({bus_if.RX_REQ_ACK, bus_if.MAIN_DATA_EN, bus_if.MAIN_DONE,
                                     bus_if.MAIN_ERR, bus_if.REQ_PENDING}), 128'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_done", 128'(done_cnt - d0), 128'd0);
        send_req(1, 64'h0000_0002_0000_ABC0, 10, lat);
        wait_idle(50);

        // Randomized traffic with random engine stalls
        issued = 0;
        req_out = 1'b0;
        rtag = 0; rlen = 1; raddr = '0;
        for (int cyc = 0; cyc < 20000 && (issued < 40 || req_out); cyc++) begin
            @(negedge clk);
            if (req_out && bus_if.RX_REQ_ACK) begin
                exp_q.push_back(mk(rtag, raddr, rlen));
                bus_if.RX_REQ = 1'b0;
                req_out = 1'b0;
                issued++;
            end else if (!req_out && issued < 40 && $urandom_range(0, 2) == 0) begin
                rtag = $urandom_range(0, 10);
                rtag = (rtag == 10) ? 3 : rtag % 3;
                raddr = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) raddr[31:2] = 30'h3FFF_FFF0 + 30'($urandom_range(0, 15));
                rlen = $urandom_range(1, 40);
                bus_if.RX_REQ_TAG = 2'(rtag);
                bus_if.RX_REQ_ADDR = raddr;
                bus_if.RX_REQ_LEN = 10'(rlen);
                bus_if.RX_REQ = 1'b1;
                req_out = 1'b1;
            end
            bus_if.ENG_STALL = ($urandom_range(0, 4) == 0);
        end
        chk("random_all_issued", 128'(issued), 128'd40);
        bus_if.RX_REQ = 1'b0;
        bus_if.ENG_STALL = 1'b0;
        wait_idle(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
